// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and FSM states.
package inst_fetch_unit_pkg;

    localparam int unsigned IFU_D_WIDTH  = 32;
    localparam int unsigned IFU_SA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs; power-of-two depth with wrapping pointers.
module fetch_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wr_data,
    output logic [WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; the head is only observed while count is non-zero.
    always_ff @(posedge Clk) begin
        if (push && !flush && !Rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues sequential reads to instruction memory, buffers the
// responses in a small prefetch FIFO and presents them in order, with redirect/flush.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned D_WIDTH  = IFU_D_WIDTH,
    parameter int unsigned SA_WIDTH = IFU_SA_WIDTH,
    parameter int unsigned PROG_LEN = 9,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    output logic [SA_WIDTH-1:0] MemAddr,
    output logic                MemEn,
    output logic                MemRW,
    input  logic [D_WIDTH-1:0]  MemData,
    output logic                InstValid,
    output logic [D_WIDTH-1:0]  InstData,
    output logic [SA_WIDTH-1:0] InstPC,
    input  logic                InstReady,
    input  logic                Redirect,
    input  logic [SA_WIDTH-1:0] RedirectPC,
    output logic                Done
);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned OW  = CW + 1;
    localparam int unsigned AW1 = SA_WIDTH + 1;
    localparam logic [AW1-1:0] PROG_END  = AW1'(PROG_LEN);
    localparam logic [OW-1:0]  DEPTH_LIM = OW'(DEPTH);

    fetch_state_t state_q, state_d;

    logic [SA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [SA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                mem_en_q, mem_en_d;
    logic                resp_valid_q;
    logic [SA_WIDTH-1:0] resp_pc_q;

    logic                redirect_act;
    logic                redirect_ok;
    logic                flush;
    logic                push;
    logic                pop;
    logic                fetch_run;
    logic [SA_WIDTH-1:0] issue_pc;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_after;
    logic [OW-1:0]       occ;
    logic                fifo_empty;
    logic [SA_WIDTH+D_WIDTH-1:0] head;

    fetch_fifo #(
        .WIDTH (SA_WIDTH + D_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data ({resp_pc_q, MemData}),
        .rd_data (head),
        .count   (count),
        .empty   (fifo_empty)
    );

    // A redirect wins over push, pop and Start in the same cycle.
    always_comb begin
        redirect_act = Redirect && ((state_q == RUN) || (state_q == DRAIN));
        redirect_ok  = ({1'b0, RedirectPC} < PROG_END);
        flush        = redirect_act;
        push         = resp_valid_q && !redirect_act;
        pop          = InstValid && InstReady && !redirect_act;
        count_after  = count + CW'(push) - CW'(pop);
        occ          = redirect_act ? '0 : (OW'(count_after) + OW'(mem_en_q));
    end

    always_comb begin
        state_d    = state_q;
        fetch_run  = 1'b0;
        issue_pc   = fetch_pc_q;
        mem_en_d   = 1'b0;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d   = RUN;
                    issue_pc  = '0;
                    fetch_run = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (redirect_act) begin
                    issue_pc = RedirectPC;
                    if (redirect_ok) begin
                        state_d   = RUN;
                        fetch_run = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (state_q == RUN) begin
                    if ({1'b0, fetch_pc_q} >= PROG_END) begin
                        state_d = DRAIN;
                    end else begin
                        fetch_run = 1'b1;
                    end
                end else if ((count == '0) && !mem_en_q && !resp_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Issue gate: everything buffered or returning plus the new read must fit.
        mem_en_d   = fetch_run && ({1'b0, issue_pc} < PROG_END) && (occ < DEPTH_LIM);
        fetch_pc_d = issue_pc + SA_WIDTH'(mem_en_d);
        if (mem_en_d) begin
            mem_addr_d = issue_pc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= '0;
            mem_addr_q   <= '0;
            mem_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            mem_addr_q   <= mem_addr_d;
            mem_en_q     <= mem_en_d;
            resp_valid_q <= mem_en_q && !redirect_act;
            resp_pc_q    <= mem_addr_q;
        end
    end

    assign MemAddr   = mem_addr_q;
    assign MemEn     = mem_en_q;
    assign MemRW     = 1'b0;
    assign InstValid = !fifo_empty;
    assign InstData  = InstValid ? head[D_WIDTH-1:0] : '0;
    assign InstPC    = InstValid ? head[D_WIDTH +: SA_WIDTH] : '0;
    assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus pushes expected fetch PCs, a monitor pops
// and compares on every accepted instruction.
module tb_inst_fetch_unit;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned PLEN = 9;
    localparam int unsigned DEP  = 4;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] MemAddr;
    logic          MemEn;
    logic          MemRW;
    logic [DW-1:0] MemData = '0;
    logic          InstValid;
    logic [DW-1:0] InstData;
    logic [AW-1:0] InstPC;
    logic          InstReady = 1'b0;
    logic          Redirect = 1'b0;
    logic [AW-1:0] RedirectPC = '0;
    logic          Done;

    logic [DW-1:0] mem [16];
    int            q[$];
    int unsigned   errors = 0;
    int unsigned   checks = 0;
    int unsigned   cyc = 0;
    int unsigned   issued = 0, accepted = 0, occ_max = 0;
    int unsigned   first_acc = 0, last_acc = 0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic [AW-1:0] hold_pc = '0;
    int            exp_pc;

    inst_fetch_unit #(
        .D_WIDTH  (DW),
        .SA_WIDTH (AW),
        .PROG_LEN (PLEN),
        .DEPTH    (DEP)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .MemAddr    (MemAddr),
        .MemEn      (MemEn),
        .MemRW      (MemRW),
        .MemData    (MemData),
        .InstValid  (InstValid),
        .InstData   (InstData),
        .InstPC     (InstPC),
        .InstReady  (InstReady),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    // Instruction memory: data returned the cycle after a read strobe, noise otherwise.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (MemEn) MemData <= mem[MemAddr];
        else       MemData <= $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Rst) begin
            issued = 0; accepted = 0; occ_max = 0; hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_valid", InstValid, 1);
                chk("hold_data", InstData, hold_data);
                chk("hold_pc", InstPC, hold_pc);
            end
            if (MemEn) issued++;
            if (issued - accepted > occ_max) occ_max = issued - accepted;
            hold_q    = InstValid && !InstReady && !Redirect;
            hold_data = InstData;
            hold_pc   = InstPC;
            if (InstValid && InstReady && !Redirect) begin
                accepted++;
                if (accepted == 1) first_acc = cyc;
                last_acc = cyc;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_word: got pc %0d, required no word", InstPC);
                end else begin
                    exp_pc = q.pop_front();
                    chk("inst_pc", InstPC, exp_pc);
                    chk("inst_data", InstData, mem[exp_pc]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic push_prog(input int from);
        for (int k = from; k < int'(PLEN); k++) q.push_back(k);
    endtask

    task automatic fill_mem(input bit rnd);
        for (int k = 0; k < 16; k++) mem[k] = rnd ? $urandom : 32'h2000_0000 + k;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Start = 1'b0; InstReady = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        q.delete();
        tick();
        Rst = 1'b0;
    endtask

    task automatic start_prog();
        Start = 1'b1;
        push_prog(0);
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && !Done; i++) tick();
        chk(name, Done, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_memaddr"}, MemAddr, 0);
        chk({tag, "_memen"}, MemEn, 0);
        chk({tag, "_memrw"}, MemRW, 0);
        chk({tag, "_instvalid"}, InstValid, 0);
        chk({tag, "_instdata"}, InstData, 0);
        chk({tag, "_instpc"}, InstPC, 0);
        chk({tag, "_done"}, Done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_issue;
        int cnt;
        int rd_at;
        int rpc;

        // Reset values, start latency, full program at full throughput.
        fill_mem(0);
        do_reset();
        chk_outputs_zero("reset");
        InstReady = 1'b1;
        start_prog();
        chk("start_memen", MemEn, 1);
        chk("start_addr", MemAddr, 0);
        tick();
        chk("valid_cycle2", InstValid, 0);
        tick();
        chk("valid_cycle3", InstValid, 1);
        chk("first_pc", InstPC, 0);
        wait_done(40, "done_full");
        chk("accepted_full", accepted, PLEN);
        chk("throughput", last_acc - first_acc, PLEN - 1);
        chk("sb_empty_full", q.size(), 0);

        // Consumer stalled: exactly DEPTH reads, head held, then release.
        do_reset();
        start_prog();
        n_issue = 0;
        for (int i = 0; i < 20; i++) begin
            if (MemEn) begin
                chk("issue_addr", MemAddr, n_issue);
                n_issue++;
            end
            if (InstValid) begin
                chk("stall_data", InstData, 32'h2000_0000);
                chk("stall_pc", InstPC, 0);
            end
            tick();
        end
        chk("issue_count", n_issue, DEP);
        chk("occ_stall", occ_max <= DEP, 1);
        InstReady = 1'b1;
        wait_done(40, "done_after_stall");
        chk("accepted_stall", accepted, PLEN);
        chk("sb_empty_stall", q.size(), 0);

        // Redirect to 6 with reads in flight.
        do_reset();
        InstReady = 1'b1;
        start_prog();
        repeat (3) tick();
        Redirect = 1'b1; RedirectPC = 4'd6;
        q.delete(); push_prog(6);
        tick();
        Redirect = 1'b0;
        wait_done(40, "done_redirect");
        chk("accepted_redirect", accepted, 4);
        chk("sb_empty_redirect", q.size(), 0);

        // Reset while three words are buffered.
        do_reset();
        start_prog();
        repeat (4) tick();
        chk("three_buffered_valid", InstValid, 1);
        Rst = 1'b1; q.delete();
        tick();
        Rst = 1'b0;
        chk_outputs_zero("rst_mid");
        InstReady = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (InstValid || MemEn) cnt++;
            tick();
        end
        chk("quiet_after_rst", cnt, 0);
        start_prog();
        wait_done(40, "done_after_rst");
        chk("sb_empty_after_rst", q.size(), 0);

        // Random back-pressure with stray Start pulses.
        for (int run = 0; run < 3; run++) begin
            fill_mem(1);
            do_reset();
            start_prog();
            for (int i = 0; i < 300 && !Done; i++) begin
                InstReady = ($urandom_range(0, 1) == 1);
                Start = ($urandom_range(0, 7) == 0);
                tick();
            end
            Start = 1'b0;
            chk("done_rand", Done, 1);
            chk("accepted_rand", accepted, PLEN);
            chk("occ_rand", occ_max <= DEP, 1);
            chk("sb_empty_rand", q.size(), 0);
        end

        // Random redirects under random back-pressure.
        for (int run = 0; run < 4; run++) begin
            fill_mem(1);
            do_reset();
            start_prog();
            rd_at = $urandom_range(1, 8);
            rpc = $urandom_range(0, PLEN);
            for (int i = 0; i < 300 && !Done; i++) begin
                InstReady = ($urandom_range(0, 1) == 1);
                if (i == rd_at) begin
                    Redirect = 1'b1; RedirectPC = AW'(rpc);
                    q.delete(); push_prog(rpc);
                end
                tick();
                Redirect = 1'b0;
            end
            chk("done_rand_redirect", Done, 1);
            chk("sb_empty_rand_redirect", q.size(), 0);
        end

        // Redirect past the program end: drain, no further reads.
        fill_mem(0);
        do_reset();
        start_prog();
        repeat (2) tick();
        Redirect = 1'b1; RedirectPC = 4'd9;
        q.delete();
        tick();
        Redirect = 1'b0;
        chk("valid_after_flush", InstValid, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (MemEn) cnt++;
            tick();
        end
        chk("no_issue_drain", cnt, 0);
        chk("done_drain", Done, 1);
        chk("accepted_drain", accepted, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
